reg_arb: RTL and testbench

- Round-robin arbiter that shares one register bank port among NUM_REQ requesters.
- The bank port is sel/wr/addr/wdata/rdata/ready; the bank drops ready after a read and re-raises it only while sel is held.
- Latches one request at a time, drives the bank, sequences the read-recovery handshake, and routes a one-cycle response back to the granted requester.
- Sits between UVM-driven agents (or CPU/DMA masters) and the bank.

---
 rtl/reg_arb_pkg.sv | 13 +
 rtl/reg_arb_rr_picker.sv | 37 +++
 rtl/reg_arb.sv | 181 ++++++++++++++++++
 tb/tb_reg_arb.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-bank round-robin arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  localparam int MAX_REQ = 4;
  localparam int IDX_W   = $clog2(MAX_REQ);

endpackage

// File: rtl/reg_arb_rr_picker.sv
// Combinational round-robin picker: first set request after rr_last, wrapping.
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  int idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(rr_last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant_idx = IDX_W'(idx);
        any       = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = any && (grant_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/reg_arb.sv
// Round-robin arbiter sharing one register-bank port among NUM_REQ requesters,
// one transaction outstanding, with read-recovery sequencing on the bank side.
module reg_arb
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_sel,
  output logic                          mem_wr,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_ready,
  output logic                          busy
);

  state_e                  state_reg, state_next;
  logic [IDX_W-1:0]        rr_last_reg, rr_last_next;
  logic [NUM_REQ-1:0]      gnt_oh_reg, gnt_oh_next;
  logic                    wr_reg, wr_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic                    mem_sel_reg, mem_sel_next;
  logic [NUM_REQ-1:0]      rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                    busy_reg, busy_next;

  logic [NUM_REQ-1:0]      pick_oh;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    take;
  logic                    accept;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (req_valid),
    .rr_last   (rr_last_reg),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // One-hot AND-OR mux of the granted requester's payload.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_wr    = sel_wr | req_wr[i];
        sel_addr  = sel_addr | addr_arr[i];
        sel_wdata = sel_wdata | wdata_arr[i];
      end
    end
  end

  assign accept = mem_sel_reg & mem_ready;

  always_comb begin
    state_next     = state_reg;
    rr_last_next   = rr_last_reg;
    gnt_oh_next    = gnt_oh_reg;
    wr_next        = wr_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    mem_sel_next   = mem_sel_reg;
    rsp_valid_next = '0;
    rsp_rdata_next = rsp_rdata_reg;
    take           = 1'b0;

    case (state_reg)
      IDLE: begin
        mem_sel_next = 1'b0;
        if (pick_any) begin
          take         = 1'b1;
          mem_sel_next = 1'b1;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        mem_sel_next = 1'b1;
        if (accept) begin
          if (wr_reg) begin
            rsp_valid_next = gnt_oh_reg;
            rsp_rdata_next = '0;
            // Drop sel for one cycle while the new payload settles, so the
            // bank never sees the old write twice.
            mem_sel_next   = 1'b0;
            if (pick_any) begin
              take = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            state_next = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        // Bank ready is low here; sel drops on the same edge it re-raises ready.
        rsp_rdata_next = mem_rdata;
        rsp_valid_next = gnt_oh_reg;
        mem_sel_next   = 1'b0;
        state_next     = IDLE;
      end
      default: begin
        mem_sel_next = 1'b0;
        state_next   = IDLE;
      end
    endcase

    if (take) begin
      rr_last_next = pick_idx;
      gnt_oh_next  = pick_oh;
      wr_next      = sel_wr;
      addr_next    = sel_addr;
      wdata_next   = sel_wdata;
    end
  end

  assign busy_next = (state_next != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_last_reg   <= IDX_W'(NUM_REQ - 1);
      gnt_oh_reg    <= '0;
      wr_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      mem_sel_reg   <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_last_reg   <= rr_last_next;
      gnt_oh_reg    <= gnt_oh_next;
      wr_reg        <= wr_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      mem_sel_reg   <= mem_sel_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      busy_reg      <= busy_next;
    end
  end

  assign req_ready = take ? pick_oh : '0;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign mem_sel   = mem_sel_reg;
  assign mem_wr    = wr_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_reg_arb.sv
// Scoreboard bench for reg_arb with a behavioural register bank that drops
// ready after each read and re-raises it while sel is held.
module tb_reg_arb;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_wr, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_sel, mem_wr, mem_ready, busy;

  typedef struct {
    logic [N-1:0]  oh;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [256];
  int            checks = 0;
  int            failures = 0;

  logic [DW-1:0] bank_mem [256];
  logic          bank_ready;
  logic          stall = 1'b0;
  int            bank_rd_cnt = 0;
  int            bank_wr_cnt = 0;
  int            cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      bank_ready <= 1'b1;
      mem_rdata  <= '0;
      for (int i = 0; i < 256; i++) bank_mem[i] <= 16'h1234;
    end else if (mem_sel && mem_ready) begin
      if (mem_wr) begin
        bank_mem[mem_addr] <= mem_wdata;
        bank_wr_cnt        <= bank_wr_cnt + 1;
      end else begin
        mem_rdata   <= bank_mem[mem_addr];
        bank_ready  <= 1'b0;
        bank_rd_cnt <= bank_rd_cnt + 1;
      end
    end else if (mem_sel && !bank_ready) begin
      bank_ready <= 1'b1;
    end
  end

  assign mem_ready = bank_ready & ~stall;

  reg_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_sel   (mem_sel),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) cyc_step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h1234;
    sb.delete();
  endtask

  // Present a request, wait for its accept pulse, record the expected response.
  task automatic send(input int id, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    req_wr[id]              = wr;
    req_addr[id*AW +: AW]   = a;
    req_wdata[id*DW +: DW]  = d;
    req_valid[id]           = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        sb.push_back('{oh: N'(1 << id), rdata: wr ? '0 : ref_mem[a]});
        if (wr) ref_mem[a] = d;
      end
    end
    cyc_step();
    req_valid[id] = 1'b0;
  endtask

  task automatic collect(output logic [N-1:0] oh, output logic [DW-1:0] rd, output bit ok);
    ok = 1'b0;
    oh = '0;
    rd = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        ok = 1'b1;
        oh = rsp_valid;
        rd = rsp_rdata;
      end
    end
    cyc_step();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '0;
    cyc_step();
    @(negedge clk);
    checks++;
    if ({mem_sel, busy, mem_wr} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: sel/busy/wr=%b expected 000", {mem_sel, busy, mem_wr});
    end
    checks++;
    if (rsp_valid !== '0 || rsp_rdata !== '0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_rsp: rsp_valid=%b rdata=%h req_ready=%b expected 0", rsp_valid, rsp_rdata, req_ready);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_mem: addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    end
    cyc_step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h1234;
    sb.delete();
  endtask

  task automatic test_read_basic();
    exp_t e;
    int   rd0;
    bit   extra;
    rd0 = bank_rd_cnt;
    req_wr[0] = 1'b0;
    req_addr[0 +: AW] = 8'h10;
    req_valid[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL rd_grant: req_ready=%b expected 001", req_ready);
    end
    sb.push_back('{oh: 3'b001, rdata: ref_mem[8'h10]});
    cyc_step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_sel, mem_wr, mem_addr, busy} !== {1'b1, 1'b0, 8'h10, 1'b1}) begin
      failures++;
      $display("FAIL rd_issue: sel=%b wr=%b addr=%h busy=%b expected 1 0 10 1", mem_sel, mem_wr, mem_addr, busy);
    end
    cyc_step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || mem_sel !== 1'b1) begin
      failures++;
      $display("FAIL rd_wait: rsp_valid=%b sel=%b expected 000 1", rsp_valid, mem_sel);
    end
    cyc_step();
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== e.oh || rsp_rdata !== e.rdata) begin
      failures++;
      $display("FAIL rd_rsp: rsp_valid=%b rdata=%h expected %b %h", rsp_valid, rsp_rdata, e.oh, e.rdata);
    end
    checks++;
    if (rsp_rdata !== 16'h1234 || mem_sel !== 1'b0) begin
      failures++;
      $display("FAIL rd_done: rdata=%h sel=%b expected 1234 0", rsp_rdata, mem_sel);
    end
    extra = 1'b0;
    repeat (3) begin
      cyc_step();
      @(negedge clk);
      if (rsp_valid !== '0) extra = 1'b1;
    end
    checks++;
    if (extra || bank_rd_cnt !== rd0 + 1) begin
      failures++;
      $display("FAIL rd_single: extra_rsp=%0d bank_reads=%0d expected 0 %0d", extra, bank_rd_cnt - rd0, 1);
    end
    cyc_step();
  endtask

  task automatic test_write_read();
    exp_t          e;
    logic [N-1:0]  oh;
    logic [DW-1:0] rd;
    bit            ok;
    send(1, 1'b1, 8'h05, 16'hBEEF, ok);
    @(negedge clk);
    checks++;
    if (!ok || {mem_sel, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h05, 16'hBEEF}) begin
      failures++;
      $display("FAIL wr_issue: ok=%0d sel=%b wr=%b addr=%h wdata=%h expected 1 1 1 05 beef",
               ok, mem_sel, mem_wr, mem_addr, mem_wdata);
    end
    cyc_step();
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== e.oh || rsp_rdata !== e.rdata || mem_sel !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsp: rsp_valid=%b rdata=%h sel=%b expected %b %h 0", rsp_valid, rsp_rdata, mem_sel, e.oh, e.rdata);
    end
    cyc_step();
    send(1, 1'b0, 8'h05, 16'h0000, ok);
    collect(oh, rd, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL wr_readback: no response (got_rsp=%0d pending=%0d) expected one", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if (oh !== e.oh || rd !== e.rdata || rd !== 16'hBEEF) begin
        failures++;
        $display("FAIL wr_readback: rsp_valid=%b rdata=%h expected %b beef", oh, rd, e.oh);
      end
    end
  endtask

  task automatic test_round_robin();
    int   n[N];
    int   order[$];
    int   wr_cycles[$];
    int   last_wr;
    bit   done;
    bit   onehot_ok;
    exp_t e;
    do_reset();
    last_wr   = bank_wr_cnt;
    done      = 1'b0;
    onehot_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      n[i] = 0;
      req_wr[i] = 1'b1;
      req_addr[i*AW +: AW]  = AW'(32 + i * 4);
      req_wdata[i*DW +: DW] = DW'(16'hA000 + i * 16);
    end
    req_valid = '1;
    for (int c = 0; c < 100 && !done; c++) begin
      int g;
      g = -1;
      @(negedge clk);
      if (bank_wr_cnt != last_wr) begin
        wr_cycles.push_back(cyc);
        last_wr = bank_wr_cnt;
      end
      if (rsp_valid != '0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rr_rsp: unexpected rsp_valid=%b expected none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.oh || rsp_rdata !== e.rdata) begin
            failures++;
            $display("FAIL rr_rsp: rsp_valid=%b rdata=%h expected %b %h", rsp_valid, rsp_rdata, e.oh, e.rdata);
          end
        end
      end
      if (req_ready != '0) begin
        if (!$onehot(req_ready)) onehot_ok = 1'b0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        order.push_back(g);
        sb.push_back('{oh: req_ready, rdata: '0});
      end
      cyc_step();
      if (g >= 0) begin
        n[g]++;
        if (n[g] < 2) begin
          req_addr[g*AW +: AW]  = AW'(32 + g * 4 + n[g]);
          req_wdata[g*DW +: DW] = DW'(16'hA000 + g * 16 + n[g]);
        end else begin
          req_valid[g] = 1'b0;
        end
      end
      done = (order.size() == 6) && (sb.size() == 0) && (req_valid == '0);
    end
    checks++;
    if (!done || order.size() != 6 || !onehot_ok) begin
      failures++;
      $display("FAIL rr_count: done=%0d grants=%0d onehot=%0d expected 1 6 1", done, order.size(), onehot_ok);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (order[k] != k % N) begin
          failures++;
          $display("FAIL rr_order: grant %0d went to %0d expected %0d", k, order[k], k % N);
        end
      end
    end
    checks++;
    if (wr_cycles.size() != 6) begin
      failures++;
      $display("FAIL rr_writes: bank writes=%0d expected 6", wr_cycles.size());
    end else begin
      for (int k = 1; k < 6; k++) begin
        checks++;
        if (wr_cycles[k] - wr_cycles[k-1] != 2) begin
          failures++;
          $display("FAIL rr_spacing: write %0d gap=%0d expected 2", k, wr_cycles[k] - wr_cycles[k-1]);
        end
      end
    end
  endtask

  task automatic test_rdwait_stall();
    exp_t          e;
    logic [N-1:0]  oh;
    logic [DW-1:0] rd;
    bit            ok;
    send(0, 1'b0, 8'h10, 16'h0000, ok);
    cyc_step();
    req_wr[1] = 1'b1;
    req_addr[AW +: AW]  = 8'h30;
    req_wdata[DW +: DW] = 16'h5555;
    req_valid[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || req_ready !== '0 || rsp_valid !== '0) begin
      failures++;
      $display("FAIL stall_rdwait: ok=%0d req_ready=%b rsp_valid=%b expected 1 000 000", ok, req_ready, rsp_valid);
    end
    cyc_step();
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== e.oh || rsp_rdata !== e.rdata) begin
      failures++;
      $display("FAIL stall_rd_rsp: rsp_valid=%b rdata=%h expected %b %h", rsp_valid, rsp_rdata, e.oh, e.rdata);
    end
    // Back in IDLE in the response cycle, so the waiting requester is granted now.
    checks++;
    if (req_ready !== 3'b010) begin
      failures++;
      $display("FAIL stall_grant: req_ready=%b expected 010", req_ready);
    end
    sb.push_back('{oh: 3'b010, rdata: '0});
    ref_mem[8'h30] = 16'h5555;
    cyc_step();
    req_valid[1] = 1'b0;
    collect(oh, rd, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL stall_wr_rsp: got_rsp=%0d pending=%0d expected 1 1", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if (oh !== e.oh || rd !== e.rdata) begin
        failures++;
        $display("FAIL stall_wr_rsp: rsp_valid=%b rdata=%h expected %b %h", oh, rd, e.oh, e.rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t          e;
    logic [N-1:0]  oh;
    logic [DW-1:0] rd;
    bit            ok;
    bit            stray;
    send(0, 1'b1, 8'h05, 16'hBEEF, ok);
    collect(oh, rd, ok);
    if (sb.size() != 0) e = sb.pop_front();
    send(1, 1'b0, 8'h05, 16'h0000, ok);
    cyc_step();
    rst = 1'b1;
    cyc_step();
    @(negedge clk);
    checks++;
    if (mem_sel !== 1'b0 || busy !== 1'b0 || rsp_valid !== '0) begin
      failures++;
      $display("FAIL rst_mid: sel=%b busy=%b rsp_valid=%b expected 0 0 000", mem_sel, busy, rsp_valid);
    end
    cyc_step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h1234;
    sb.delete();
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== '0) stray = 1'b1;
      cyc_step();
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL rst_no_rsp: stray rsp_valid seen=%0d expected 0", stray);
    end
    send(1, 1'b0, 8'h05, 16'h0000, ok);
    collect(oh, rd, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL rst_reread: got_rsp=%0d pending=%0d expected 1 1", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if (oh !== e.oh || rd !== e.rdata || rd !== 16'h1234) begin
        failures++;
        $display("FAIL rst_reread: rsp_valid=%b rdata=%h expected %b 1234", oh, rd, e.oh);
      end
    end
  endtask

  task automatic test_not_ready();
    exp_t          e;
    logic [N-1:0]  oh;
    logic [DW-1:0] rd;
    bit            ok;
    stall = 1'b1;
    send(0, 1'b1, 8'h40, 16'hA5A5, ok);
    req_wr[1] = 1'b0;
    req_addr[AW +: AW] = 8'h40;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mem_sel !== 1'b1 || req_ready !== '0 || rsp_valid !== '0) begin
        failures++;
        $display("FAIL nr_hold: cycle %0d sel=%b req_ready=%b rsp_valid=%b expected 1 000 000",
                 k, mem_sel, req_ready, rsp_valid);
      end
      cyc_step();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b010) begin
      failures++;
      $display("FAIL nr_regrant: req_ready=%b expected 010", req_ready);
    end
    sb.push_back('{oh: 3'b010, rdata: ref_mem[8'h40]});
    cyc_step();
    req_valid[1] = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== e.oh || rsp_rdata !== e.rdata) begin
      failures++;
      $display("FAIL nr_wr_rsp: rsp_valid=%b rdata=%h expected %b %h", rsp_valid, rsp_rdata, e.oh, e.rdata);
    end
    cyc_step();
    collect(oh, rd, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL nr_rd_rsp: got_rsp=%0d pending=%0d expected 1 1", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if (oh !== e.oh || rd !== e.rdata || rd !== 16'hA5A5) begin
        failures++;
        $display("FAIL nr_rd_rsp: rsp_valid=%b rdata=%h expected %b a5a5", oh, rd, e.oh);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1;
    test_reset();
    test_read_basic();
    test_write_read();
    test_round_robin();
    test_rdwait_stall();
    test_reset_mid();
    test_not_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
